apuf_eval_ctrl: RTL



---
 rtl/apuf_pkg.sv | 31 +++
 rtl/apuf_settle_timer.sv | 32 +++
 rtl/apuf_eval_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/apuf_pkg.sv
// apuf_pkg: shared types and helpers for the arbiter-PUF evaluation controller.
//   apuf_state_e  - controller FSM states
//   cnt_width()   - width of the vote counters for a given VOTE_N
//   timer_width() - width of the settle timer for a given SETTLE_CYC
//   params_ok()   - parameter legality check used at elaboration
package apuf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } apuf_state_e;

  // Enough bits to hold the values 0..vote_n inclusive.
  function automatic int cnt_width(input int vote_n);
    return $clog2(vote_n + 1);
  endfunction

  // A single-cycle settle time still needs a 1-bit counter.
  function automatic int timer_width(input int settle_cyc);
    return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
  endfunction

  // VOTE_N must be odd (so a majority always exists) and SETTLE_CYC >= 1.
  function automatic bit params_ok(input int vote_n, input int settle_cyc);
    return (vote_n >= 1) && ((vote_n % 2) == 1) && (settle_cyc >= 1);
  endfunction

endpackage

// File: rtl/apuf_settle_timer.sv
// apuf_settle_timer: loadable down-counter timing the CLEAR and LAUNCH phases.
//   clk, resetn  - clock, synchronous active-low reset
//   i_load       - load i_load_val (has priority over i_en)
//   i_en         - decrement while non-zero
//   i_load_val   - value loaded on i_load
//   o_zero       - counter is zero
module apuf_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apuf_eval_ctrl.sv
// apuf_eval_ctrl: sequences VOTE_N arbiter-PUF evaluations for one challenge
// and returns a majority-voted response bit with a stability flag.
//   clk, resetn               - clock, synchronous active-low reset
//   start_valid/start_ready   - challenge request handshake
//   challenge                 - challenge, captured on accept
//   puf_chal                  - registered stage selects to the delay chain
//   puf_clr                   - registered arbiter clear
//   puf_launch                - registered race launch edge
//   puf_resp                  - arbiter output
//   resp_valid/resp_ready     - result handshake
//   resp_bit                  - majority response
//   resp_stable               - all samples agreed
//   ones_count                - number of samples equal to 1
//   busy                      - controller not idle
module apuf_eval_ctrl
  import apuf_pkg::*;
#(
  parameter int CHAL_W     = 64,
  parameter int SETTLE_CYC = 8,
  parameter int VOTE_N     = 7,
  parameter int CNT_W      = cnt_width(VOTE_N)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [CHAL_W-1:0] challenge,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_clr,
  output logic              puf_launch,
  input  logic              puf_resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic              resp_stable,
  output logic [CNT_W-1:0]  ones_count,
  output logic              busy
);

  if (!params_ok(VOTE_N, SETTLE_CYC)) begin : g_param_check
    $error("apuf_eval_ctrl: VOTE_N must be odd and >= 1, SETTLE_CYC must be >= 1");
  end

  localparam int              TMR_W     = timer_width(SETTLE_CYC);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_EVAL = CNT_W'(VOTE_N - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(VOTE_N / 2);
  localparam logic [CNT_W-1:0] VOTE_FULL = CNT_W'(VOTE_N);

  apuf_state_e r_state;
  apuf_state_e w_state_nxt;

  logic [CHAL_W-1:0] r_chal;
  logic              r_clr;
  logic              r_launch;
  logic [CNT_W-1:0]  r_ones;
  logic [CNT_W-1:0]  r_eval;
  logic              r_resp_bit;
  logic              r_resp_stable;

  logic              w_tmr_zero;
  logic              w_tmr_load;
  logic              w_tmr_en;
  logic              w_accept;
  logic              w_last_eval;
  logic              w_clr_nxt;
  logic              w_launch_nxt;
  logic [CNT_W-1:0]  w_ones_nxt;

  apuf_settle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (TMR_LOAD),
    .o_zero     (w_tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_valid)  w_state_nxt = CLEAR;
      CLEAR:   if (w_tmr_zero)   w_state_nxt = LAUNCH;
      LAUNCH:  if (w_tmr_zero)   w_state_nxt = SAMPLE;
      SAMPLE:  w_state_nxt = w_last_eval ? DONE : CLEAR;
      DONE:    if (resp_ready)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control decode. puf_clr/puf_launch are registered, so they are
  // computed from the next state and land in step with the state register.
  always_comb begin
    w_accept     = (r_state == IDLE) && start_valid;
    w_last_eval  = (r_eval == LAST_EVAL);
    w_tmr_load   = w_accept
                || ((r_state == CLEAR) && w_tmr_zero)
                || ((r_state == SAMPLE) && !w_last_eval);
    w_tmr_en     = (r_state == CLEAR) || (r_state == LAUNCH);
    w_clr_nxt    = (w_state_nxt == CLEAR);
    w_launch_nxt = (w_state_nxt == LAUNCH) || (w_state_nxt == SAMPLE);
    w_ones_nxt   = r_ones + CNT_W'(puf_resp);
  end

  // Challenge register, phase outputs and vote accumulator.
  // resp_bit/resp_stable are latched on entry to DONE so they hold their
  // values through IDLE while ones_count is cleared by the next accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_chal        <= '0;
      r_clr         <= 1'b0;
      r_launch      <= 1'b0;
      r_ones        <= '0;
      r_eval        <= '0;
      r_resp_bit    <= 1'b0;
      r_resp_stable <= 1'b0;
    end else begin
      r_clr    <= w_clr_nxt;
      r_launch <= w_launch_nxt;
      if (w_accept) begin
        r_chal <= challenge;
        r_ones <= '0;
        r_eval <= '0;
      end else if (r_state == SAMPLE) begin
        r_ones <= w_ones_nxt;
        r_eval <= r_eval + CNT_W'(1);
        if (w_last_eval) begin
          r_resp_bit    <= (w_ones_nxt > HALF);
          r_resp_stable <= (w_ones_nxt == '0) || (w_ones_nxt == VOTE_FULL);
        end
      end
    end
  end

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign resp_valid  = (r_state == DONE);
  assign puf_chal    = r_chal;
  assign puf_clr     = r_clr;
  assign puf_launch  = r_launch;
  assign ones_count  = r_ones;
  assign resp_bit    = r_resp_bit;
  assign resp_stable = r_resp_stable;

endmodule
